// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter/receiver pair.
//   - uart_state_e    : receiver/transmitter frame state (2-bit).
//   - *_DEFAULT       : default baud ratio and frame format. The tx and rx
//                       sides both use these, so they agree on the framing.
//   - half_of()       : mid-bit offset used to land samples mid-bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_BAUD_RATIO_DEFAULT = 12000000 / 9600;
  localparam int unsigned UART_DATA_BITS_DEFAULT  = 8;
  localparam int unsigned UART_STOP_BITS_DEFAULT  = 2;

  // Half a bit period, rounded down.
  function automatic int unsigned half_of(input int unsigned ratio);
    return ratio / 2;
  endfunction

  localparam int unsigned HALF_DEFAULT = half_of(UART_BAUD_RATIO_DEFAULT);

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous rx line into the clk domain.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   rx   in  asynchronous serial line
//   rx_s out synchronized line (after two flops)
//   fall out one-cycle falling-edge strobe on rx_s
// All flops reset to 0. A falling edge can therefore only be reported after
// the line has been seen high, so a line held low through reset release does
// not look like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = hist_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, UART_DATA_BITS data bits LSB first,
// UART_STOP_BITS stop bits, no parity. Bits are timed by counting clk cycles.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   rx          in  asynchronous serial line, idles high
//   rx_data     out received byte, valid while rx_valid
//   rx_valid    out output register holds an unconsumed byte
//   rx_ready    in  consumer accepts rx_data when rx_valid && rx_ready
//   busy        out frame reception in progress
//   frame_error out one-cycle pulse, a stop-bit sample was 0 (byte dropped)
//   overrun     out one-cycle pulse, good frame while output full (byte dropped)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_2_CLOCK_RATIO = UART_BAUD_RATIO_DEFAULT,
  parameter int unsigned UART_DATA_BITS     = UART_DATA_BITS_DEFAULT,
  parameter int unsigned UART_STOP_BITS     = UART_STOP_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      busy,
  output logic                      frame_error,
  output logic                      overrun
);

  localparam int unsigned HALF     = half_of(BAUD_2_CLOCK_RATIO);
  localparam int unsigned MAX_BITS = (UART_DATA_BITS > UART_STOP_BITS) ? UART_DATA_BITS
                                                                       : UART_STOP_BITS;
  localparam int CD_W = $clog2(BAUD_2_CLOCK_RATIO);
  localparam int BC_W = $clog2(MAX_BITS + 1);

  localparam logic [CD_W-1:0] HALF_M1   = CD_W'(HALF - 1);
  localparam logic [CD_W-1:0] RATIO_M1  = CD_W'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(UART_DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(UART_STOP_BITS - 1);

  logic rx_s;
  logic fall;

  uart_state_e               state_q, state_d;
  logic [CD_W-1:0]           cd_q, cd_d;
  logic [BC_W-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      err_q, err_d;
  logic                      commit_q, commit_d;

  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_error_q, frame_error_d;
  logic                      overrun_q, overrun_d;
  logic                      good;
  logic                      load;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // Frame state machine: next-state logic.
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    err_d    = err_q;
    commit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cd_d    = '0;
        end
      end
      START: begin
        if (cd_q == HALF_M1) begin
          cd_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
            err_d   = 1'b0;
          end else begin
            // Line came back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cd_d = cd_q + CD_W'(1);
        end
      end
      DATA: begin
        if (cd_q == RATIO_M1) begin
          cd_d = '0;
          // Shift in at the MSB so the first (LSB) bit ends at bit 0.
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end else begin
          cd_d = cd_q + CD_W'(1);
        end
      end
      STOP: begin
        if (cd_q == RATIO_M1) begin
          cd_d = '0;
          if (!rx_s) begin
            err_d = 1'b1;
          end
          if (bit_q == STOP_LAST) begin
            // Leave at the last stop mid-sample so the next start bit can
            // be caught even on a back-to-back line.
            state_d  = IDLE;
            commit_d = 1'b1;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end else begin
          cd_d = cd_q + CD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: the commit cycle is the first IDLE cycle after the
  // last stop sample; it competes with the consumer handshake here.
  always_comb begin
    good          = commit_q & ~err_q;
    load          = good & (~rx_valid_q | rx_ready);
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_error_d = commit_q & err_q;
    overrun_d     = good & rx_valid_q & ~rx_ready;
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cd_q          <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      err_q         <= 1'b0;
      commit_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cd_q          <= cd_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      err_q         <= err_d;
      commit_q      <= commit_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int R          = 16;
  localparam int HALF       = R / 2;
  localparam int FRAME_CYC  = (8 + 2) * R;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  // Behavioural model state
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  int         ev_kind[int];
  logic [7:0] ev_byte[int];
  bit         busy_exp[int];

  // Observed DUT activity
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] beats[$];

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(R),
    .UART_DATA_BITS(8),
    .UART_STOP_BITS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Model: frame outcomes are scheduled by edge number when they are sent;
  // each edge applies the scheduled outcome and the ready/valid handshake.
  always @(posedge clk) begin
    bit consumed;
    cyc = cyc + 1;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      ev_kind.delete();
      ev_byte.delete();
      busy_exp.delete();
    end else begin
      consumed = m_valid && rx_ready;
      if (ev_kind.exists(cyc)) begin
        if (ev_kind[cyc] == 2) begin
          m_fe = 1'b1;
        end else if (!m_valid || rx_ready) begin
          m_valid  = 1'b1;
          m_data   = ev_byte[cyc];
          consumed = 1'b0;
        end else begin
          m_ov = 1'b1;
        end
      end
      if (consumed) m_valid = 1'b0;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic exp_busy;
    if (cyc > 0) begin
      exp_busy = busy_exp.exists(cyc);
      n_checks++;
      if ({rx_valid, rx_data, busy, frame_error, overrun} !==
          {m_valid, m_data, exp_busy, m_fe, m_ov}) begin
        n_errors++;
        $display("FAIL outputs@%0d: got valid=%b data=%h busy=%b fe=%b ov=%b, expected valid=%b data=%h busy=%b fe=%b ov=%b",
                 cyc, rx_valid, rx_data, busy, frame_error, overrun,
                 m_valid, m_data, exp_busy, m_fe, m_ov);
      end
      if (frame_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        beats.push_back(rx_data);
        $display("beat @%0d data=%h", cyc, rx_data);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2ms;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("check %s ok (%0h)", name, got);
    end
  endtask

  // Falling edge driven after edge n0 is picked up 3 edges later; a frame
  // then occupies HALF + 10 bit times, and the result is visible one edge later.
  task automatic register_frame(input int n0, input logic [7:0] b, input bit err);
    for (int n = n0 + 3; n <= n0 + 2 + HALF + FRAME_CYC; n++) busy_exp[n] = 1'b1;
    ev_kind[n0 + 4 + HALF + FRAME_CYC] = err ? 2 : 1;
    ev_byte[n0 + 4 + HALF + FRAME_CYC] = b;
  endtask

  // stops[0] = first stop bit, stops[1] = second. cut > 0 stops driving early.
  task automatic send_frame(input logic [7:0] b, input logic [1:0] stops, input int cut);
    logic [10:0] bits;
    int t;
    bits = {stops[1], stops[0], b, 1'b0};
    t = 0;
    register_frame(cyc, b, stops != 2'b11);
    $display("send @%0d byte=%h stops=%b cut=%0d", cyc, b, stops, cut);
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      for (int j = 0; j < R; j++) begin
        if (cut > 0 && t == cut) return;
        tick(1);
        t++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    for (int n = cyc + 3; n <= cyc + 2 + HALF; n++) busy_exp[n] = 1'b1;
    $display("glitch @%0d len=%0d", cyc, len);
    rx = 1'b0;
    tick(len);
    rx = 1'b1;
  endtask

  initial begin
    int lat;
    int bcnt;
    int base_fe;
    int base_ov;
    int base_beats;
    logic [7:0] lat_data;
    logic [7:0] rb;
    logic [1:0] st;
    int sel;
    int gap;

    tick(4);
    rst = 1'b0;
    tick(5);

    // Single frame 0x42: latency, busy length, data.
    lat = -1;
    bcnt = 0;
    lat_data = 8'h00;
    base_beats = beats.size();
    fork
      send_frame(8'h42, 2'b11, 0);
      begin
        int s;
        s = cyc;
        for (int k = 0; k < 260; k++) begin
          tick(1);
          if (busy === 1'b1) bcnt++;
          if (rx_valid === 1'b1 && lat < 0) begin
            lat = cyc - s;
            lat_data = rx_data;
          end
        end
      end
    join
    check("latency_0x42", lat, 172);
    check("busy_cycles_0x42", bcnt, 168);
    check("data_0x42", {24'h0, lat_data}, 32'h42);
    check("beats_0x42", beats.size() - base_beats, 1);

    // Back-to-back frames.
    base_beats = beats.size();
    base_fe = fe_cnt;
    base_ov = ov_cnt;
    send_frame(8'h55, 2'b11, 0);
    send_frame(8'hA3, 2'b11, 0);
    send_frame(8'h00, 2'b11, 0);
    send_frame(8'hFF, 2'b11, 0);
    tick(200);
    check("b2b_count", beats.size() - base_beats, 4);
    if (beats.size() - base_beats == 4) begin
      check("b2b_0", {24'h0, beats[base_beats]},     32'h55);
      check("b2b_1", {24'h0, beats[base_beats + 1]}, 32'hA3);
      check("b2b_2", {24'h0, beats[base_beats + 2]}, 32'h00);
      check("b2b_3", {24'h0, beats[base_beats + 3]}, 32'hFF);
    end
    check("b2b_no_fe", fe_cnt - base_fe, 0);
    check("b2b_no_ov", ov_cnt - base_ov, 0);

    // Framing error then a good frame.
    base_beats = beats.size();
    base_fe = fe_cnt;
    send_frame(8'h3C, 2'b01, 0);
    tick(30);
    send_frame(8'h11, 2'b11, 0);
    tick(200);
    check("ferr_pulses", fe_cnt - base_fe, 1);
    check("ferr_next_count", beats.size() - base_beats, 1);
    if (beats.size() > base_beats) check("ferr_next_data", {24'h0, beats[$]}, 32'h11);

    // Short glitch.
    base_beats = beats.size();
    glitch(5);
    tick(40);
    check("glitch_no_beat", beats.size() - base_beats, 0);

    // Overrun.
    base_ov = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h01, 2'b11, 0);
    tick(10);
    send_frame(8'h02, 2'b11, 0);
    tick(20);
    check("ovr_pulses", ov_cnt - base_ov, 1);
    check("ovr_valid", {31'h0, rx_valid}, 1);
    check("ovr_data", {24'h0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_consumed", {31'h0, rx_valid}, 0);
    tick(5);

    // Line held low through reset release.
    rx = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(6);
    rx = 1'b1;
    tick(40);
    check("lowrst_busy", {31'h0, busy}, 0);
    check("lowrst_valid", {31'h0, rx_valid}, 0);

    // Reset in the middle of a data bit, with a byte pending.
    send_frame(8'h5A, 2'b11, 0);
    tick(20);
    check("pend_valid", {31'h0, rx_valid}, 1);
    send_frame(8'h77, 2'b11, 4 * R + 5);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_outs", {busy, rx_valid, rx_data, frame_error, overrun}, 0);
    rx_ready = 1'b1;
    tick(20);
    base_beats = beats.size();
    send_frame(8'h77, 2'b11, 0);
    tick(200);
    check("postrst_count", beats.size() - base_beats, 1);
    if (beats.size() > base_beats) check("postrst_data", {24'h0, beats[$]}, 32'h77);

    // Randomized traffic with random ready, stop-bit errors and glitches.
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rb = 8'($urandom);
      sel = $urandom_range(0, 7);
      st = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b00 : 2'b11;
      send_frame(rb, st, 0);
      gap = $urandom_range(0, 30);
      if (st != 2'b11) gap += 20;
      tick(gap);
      if ($urandom_range(0, 4) == 0) begin
        glitch($urandom_range(1, 6));
        tick(12 + $urandom_range(0, 10));
      end
    end
    rand_ready = 1'b0;
    tick(2);
    rx_ready = 1'b1;
    tick(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver that consumes the line driven by the team's UART transmitter, the same frame format at the same baud.
- Frame: 1 start bit, UART_DATA_BITS data bits LSB first, UART_STOP_BITS stop bits, no parity.
- Oversamples by clock count, recovers each byte and presents it on a one-entry valid/ready output register.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- BAUD_2_CLOCK_RATIO, 12000000/9600 (1250): clk cycles per bit. Must be at least 4.
- UART_DATA_BITS, 8: data bits per frame.
- UART_STOP_BITS, 2: stop bits per frame. All of them are checked.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line. Idles high.
- rx_data  out  UART_DATA_BITS  received byte. Valid while rx_valid=1.
- rx_valid  out  1  output register holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- busy  out  1  frame reception in progress (state != IDLE).
- frame_error  out  1  one-cycle pulse: a stop-bit sample was 0. The byte is dropped.
- overrun  out  1  one-cycle pulse: a good frame completed while the output was full. The new byte is dropped.

Behaviour:
Reset values:
- rx_data=0, rx_valid=0, busy=0, frame_error=0, overrun=0.
- State=IDLE, counters=0.
- Synchronizer flops and the edge-history flop reset to 0. A falling edge therefore requires the line to be seen high first, so a line held low through reset release never triggers a false start.
- Reset asserted mid-frame aborts the frame with no error pulse. Reset has priority over everything else.

Input stage:
- rx passes through 2 flops to give rx_s.
- A third flop gives rx_d.
- fall = rx_d & ~rx_s.

Definitions:
- HALF = BAUD_2_CLOCK_RATIO/2, integer divide.
- cd_count width = $clog2(BAUD_2_CLOCK_RATIO).
- bit_count width = $clog2(max(UART_DATA_BITS, UART_STOP_BITS)+1).

State machine:
- IDLE: on fall go to START with cd_count=0. Otherwise stay.
- START: cd_count increments each cycle. At cd_count==HALF-1, sample rx_s:
  - 0 → DATA with cd_count=0, bit_count=0.
  - 1 → IDLE. This is a glitch reject and produces no pulse.
- DATA: cd_count counts to BAUD_2_CLOCK_RATIO-1, then wraps to 0 and samples rx_s.
  - Each sample shifts into the MSB of the shift register (LSB-first reassembly) and increments bit_count.
  - After the UART_DATA_BITS-th sample go to STOP with bit_count=0.
- STOP: sample at the same wrap point.
  - Any 0 sample sets the sticky err_f flag for this frame.
  - After the UART_STOP_BITS-th sample, go to IDLE in the same cycle and commit the frame (see below).

Commit (the cycle the state becomes IDLE), outputs visible on the next cycle:
- err_f=1: frame_error pulses. The output register is untouched.
- Else if rx_valid=0, or rx_valid && rx_ready in this same cycle: load rx_data and set rx_valid=1. A simultaneous consume plus load keeps rx_valid=1 with no gap and no overrun.
- Else: overrun pulses. rx_data is unchanged and the new byte is discarded.

Handshake:
- rx_valid is held, with rx_data stable, until the cycle rx_valid && rx_ready.
- rx_valid clears on the following edge unless a commit coincides with that cycle.
- rx_ready has no effect while rx_valid=0.

Latency and throughput:
- Returning to IDLE at the last stop-bit mid-sample allows back-to-back frames. The next fall can be accepted on the cycle immediately after the commit.
- From the rx falling edge to rx_valid high: 3 cycles of sync/edge detect, plus HALF + (UART_DATA_BITS+UART_STOP_BITS)·BAUD_2_CLOCK_RATIO, plus 1.
- A fall seen while not in IDLE is ignored.

Decomposition:
- Package uart_pkg:
  - State enum IDLE/START/DATA/STOP (2-bit).
  - Shared default localparams for baud ratio, data bits and stop bits, so uart_tx and uart_rx agree.
  - Helper constant HALF.
- Sub-module uart_rx_sync: 2-flop synchronizer plus edge-history flop, with outputs rx_s and fall, and resets to 0.
- Everything else lives in uart_rx.

Test Plan:
All scenarios use BAUD_2_CLOCK_RATIO=16, 8 data bits, 2 stop bits, rx_ready=1 unless noted.
- Single frame 0x42 ('B'): rx_valid pulses once with rx_data=0x42, no error pulses, busy high for 8+16·10 cycles, first rx_valid 3+8+160+1=172 cycles after the rx fall.
- Back-to-back frames 0x55, 0xA3, 0x00, 0xFF with stop bits only 10 bit-times apart: four rx_valid beats in order with matching data, no frame_error, no overrun.
- Frame 0x3C with the second stop bit driven 0: frame_error pulses exactly 1 cycle and rx_valid stays 0. A following good frame 0x11 is received correctly.
- 5-cycle low glitch on an idle line: busy rises then falls at the START mid-sample, no rx_valid, no error pulse.
- rx_ready=0, send 0x01 then 0x02: rx_data stays 0x01 with rx_valid=1, overrun pulses once at the second commit. Raising rx_ready for 1 cycle clears rx_valid.
- Hold rx low through reset release, then raise it: no spurious frame. Asserting rst mid-data-bit of frame 0x77: busy=0 and all outputs 0 next cycle. A subsequent frame 0x77 is received correctly.
